// File: rtl/alu_exec_stage_if.sv
// Handshake/bus bundle between the ALU-control decoder, the execute stage and MEM.
// The slave view belongs to the execute stage; the master view drives it.
interface alu_exec_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal_op;

    modport slave (
        input  in_valid, alu_ctl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal_op
    );

    modport master (
        output in_valid, alu_ctl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal_op
    );
endinterface

// File: rtl/alu_exec_stage.sv
// MIPS execute stage: combinational ALU feeding a 2-entry skid buffer (main + skid),
// in-order results, no combinational out_ready -> in_ready path.
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    alu_exec_stage_if.slave  bus
);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_XOR = 4'b1101;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             overflow;
        logic             illegal_op;
    } res_t;

    res_t             res_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] diff_c;
    logic             acc_c;
    logic             pop_c;

    res_t m_q, m_d, s_q, s_d;
    logic m_v_q, m_v_d, s_v_q, s_v_d;

    // ALU: result and flags from the operands presented this cycle
    always_comb begin
        res_c  = '0;
        sum_c  = bus.op_a + bus.op_b;
        diff_c = bus.op_a - bus.op_b;
        case (bus.alu_ctl)
            CTL_ADD: begin
                res_c.result   = sum_c;
                res_c.overflow = (bus.op_a[MSB] == bus.op_b[MSB]) && (sum_c[MSB] != bus.op_a[MSB]);
            end
            CTL_SUB: begin
                res_c.result   = diff_c;
                res_c.overflow = (bus.op_a[MSB] != bus.op_b[MSB]) && (diff_c[MSB] != bus.op_a[MSB]);
            end
            CTL_AND: res_c.result = bus.op_a & bus.op_b;
            CTL_OR:  res_c.result = bus.op_a | bus.op_b;
            CTL_NOR: res_c.result = ~(bus.op_a | bus.op_b);
            CTL_XOR: res_c.result = bus.op_a ^ bus.op_b;
            CTL_SLT: res_c.result = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            default: res_c.illegal_op = 1'b1;
        endcase
        res_c.zero = (res_c.result == '0);
    end

    assign acc_c = bus.in_valid && !s_v_q;
    assign pop_c = m_v_q && bus.out_ready;

    // Skid buffer next state; M is always the older entry when both are valid
    always_comb begin
        m_d   = m_q;
        s_d   = s_q;
        m_v_d = m_v_q;
        s_v_d = s_v_q;
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (!m_v_q) begin
            if (acc_c) begin
                m_d   = res_c;
                m_v_d = 1'b1;
            end
        end else if (pop_c) begin
            if (acc_c) begin
                m_d = res_c;
            end else if (s_v_q) begin
                m_d   = s_q;
                s_v_d = 1'b0;
            end else begin
                m_v_d = 1'b0;
            end
        end else if (acc_c) begin
            s_d   = res_c;
            s_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q   <= '0;
            s_q   <= '0;
            m_v_q <= 1'b0;
            s_v_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            s_q   <= s_d;
            m_v_q <= m_v_d;
            s_v_q <= s_v_d;
        end
    end

    assign bus.in_ready   = !s_v_q;
    assign bus.out_valid  = m_v_q;
    assign bus.result     = m_q.result;
    assign bus.zero       = m_q.zero;
    assign bus.overflow   = m_q.overflow;
    assign bus.illegal_op = m_q.illegal_op;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: driver pushes hand-computed results on accept,
// a negedge monitor pops and compares every transfer the DUT presents.
module tb_alu_exec_stage;
    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        i;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    alu_exec_stage_if #(.WIDTH(32)) bus ();

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transfer happens at the next posedge when out_valid && out_ready here
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result 0x%0h expected no output", bus.result);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_bundle",
                      {29'b0, bus.result, bus.zero, bus.overflow, bus.illegal_op},
                      {29'b0, mon_e});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Holds the op until accepted; returns 1ns after the accepting edge with in_valid still high
    task automatic send(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.alu_ctl  = ctl;
        bus.op_a     = a;
        bus.op_b     = b;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready && !flush) begin
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_ctl   = 4'b0000;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;
        tick(2);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_illegal", bus.illegal_op, 0);
        rst_n = 1'b1;

        // single add: one-cycle latency
        send(4'b0010, 32'd5, 32'd7, '{32'd12, 1'b0, 1'b0, 1'b0});
        idle();
        check("lat_out_valid", bus.out_valid, 1);
        check("lat_result", bus.result, 32'd12);
        tick(2);

        // back-to-back flag corner cases
        send(4'b0010, 32'h7FFF_FFFF, 32'h1,         '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
        send(4'b0110, 32'd9,         32'd9,         '{32'h0,         1'b1, 1'b0, 1'b0});
        send(4'b0110, 32'h8000_0000, 32'h1,         '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
        send(4'b0111, 32'hFFFF_FFFF, 32'h1,         '{32'h1,         1'b0, 1'b0, 1'b0});
        send(4'b0111, 32'h1,         32'hFFFF_FFFF, '{32'h0,         1'b1, 1'b0, 1'b0});
        send(4'b1111, 32'd3,         32'd4,         '{32'h0,         1'b1, 1'b0, 1'b1});
        send(4'b0010, 32'hFFFF_FFFF, 32'h1,         '{32'h0,         1'b1, 1'b0, 1'b0});
        idle();
        tick(4);
        check("drain_flags", sb_q.size(), 0);
        check("idle_out_valid", bus.out_valid, 0);

        // backpressure: fill both entries, then release
        send(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'hF000_F000, 1'b0, 1'b0, 1'b0});
        bus.out_ready = 1'b0;
        send(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0});
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_held_result", bus.result, 32'hF000_F000);
        fork
            begin
                send(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'h000F_000F, 1'b0, 1'b0, 1'b0});
                send(4'b1101, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0});
                idle();
            end
            begin
                tick(3);
                check("bp_stall_result", bus.result, 32'hF000_F000);
                bus.out_ready = 1'b1;
            end
        join
        tick(6);
        check("drain_bp", sb_q.size(), 0);

        // flush with both entries full
        bus.out_ready = 1'b0;
        send(4'b0010, 32'd1, 32'd2, '{32'd3, 1'b0, 1'b0, 1'b0});
        send(4'b0010, 32'd2, 32'd2, '{32'd4, 1'b0, 1'b0, 1'b0});
        check("fl_full_in_ready", bus.in_ready, 0);
        bus.alu_ctl = 4'b0110;
        bus.op_a    = 32'd10;
        bus.op_b    = 32'd3;
        flush       = 1'b1;
        tick(1);
        flush = 1'b0;
        idle();
        sb_q.delete();
        check("fl_out_valid", bus.out_valid, 0);
        check("fl_in_ready", bus.in_ready, 1);

        // flush while an accept would otherwise happen
        send(4'b0010, 32'd3, 32'd3, '{32'd6, 1'b0, 1'b0, 1'b0});
        bus.op_a = 32'd4;
        bus.op_b = 32'd4;
        flush    = 1'b1;
        tick(1);
        flush = 1'b0;
        idle();
        sb_q.delete();
        check("fl2_out_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        tick(4);
        check("fl2_still_empty", bus.out_valid, 0);

        // reset in the middle of a stalled transfer
        bus.out_ready = 1'b0;
        send(4'b0010, 32'd1, 32'd2, '{32'd3, 1'b0, 1'b0, 1'b0});
        send(4'b0010, 32'd5, 32'd5, '{32'd10, 1'b0, 1'b0, 1'b0});
        idle();
        check("mr_full_in_ready", bus.in_ready, 0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        sb_q.delete();
        check("mr_out_valid", bus.out_valid, 0);
        check("mr_in_ready", bus.in_ready, 1);
        check("mr_result", bus.result, 0);
        check("mr_zero", bus.zero, 0);
        check("mr_overflow", bus.overflow, 0);
        check("mr_illegal", bus.illegal_op, 0);
        bus.out_ready = 1'b1;
        send(4'b0010, 32'd1, 32'd1, '{32'd2, 1'b0, 1'b0, 1'b0});
        idle();
        check("mr_lat_valid", bus.out_valid, 1);
        check("mr_lat_result", bus.result, 32'd2);
        tick(4);
        check("drain_final", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage of the MIPS datapath, directly downstream of the ALU-control decoder.
- Accepts two 32-bit operands plus the 4-bit ALU control code through a valid/ready handshake, computes the ALU result and flags, and registers them toward the MEM stage.
- Contains a 2-entry skid buffer (output register plus skid register). This sustains one result per cycle under backpressure, with no combinational path from out_ready to in_ready.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous discard of all buffered results (branch/exception).
- in_valid  input  1  upstream presents a valid operation.
- in_ready  output  1  stage can accept an operation this cycle.
- alu_ctl  input  4  ALU control code from the ALU-control decoder.
- op_a  input  WIDTH  operand A (rs).
- op_b  input  WIDTH  operand B (rt or sign-extended immediate).
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- result  output  WIDTH  ALU result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (add/sub only).
- illegal_op  output  1  alu_ctl is not a defined code.

Behaviour:
- Op decode on alu_ctl:
  - 0010: add, A+B.
  - 0110: sub, A−B.
  - 0000: and.
  - 0001: or.
  - 1100: nor.
  - 1101: xor.
  - 0111: slt, signed; result = {WIDTH-1 zeros, (A<B)}.
- Any other code: result=0, zero=1, overflow=0, illegal_op=1.
- Arithmetic is modulo 2^WIDTH; carry is discarded.
- overflow:
  - add: A[31]==B[31] && R[31]!=A[31].
  - sub: A[31]!=B[31] && R[31]!=A[31].
  - Forced 0 for all other ops.
- Result bundle = {result, zero, overflow, illegal_op}. It is computed combinationally from inputs and captured only on accept (in_valid && in_ready).
- State: main register (M, drives outputs) with valid bit m_v; skid register (S) with valid bit s_v.
- Derived signals:
  - in_ready = !s_v, a registered source.
  - out_valid = m_v.
- Transitions, evaluated per cycle with acc = in_valid && in_ready and pop = m_v && out_ready:
  - !m_v && acc: M<=new, m_v<=1.
  - m_v && pop && acc: M<=new.
  - m_v && pop && !acc && s_v: M<=S, s_v<=0.
  - m_v && pop && !acc && !s_v: m_v<=0.
  - m_v && !pop && acc: S<=new, s_v<=1. in_ready drops the next cycle.
  - Both full: in_ready=0; hold until pop.
- Ordering is strictly FIFO. When s_v=1, M is always older than S.
- Latency: 1 cycle from accept to out_valid when empty. Throughput is 1 op/cycle with out_ready held high.
- Outputs are stable while out_valid && !out_ready.
- flush=1: m_v<=0, s_v<=0 next cycle. Any accept in that cycle is discarded, but in_ready still reflects current state. flush beats every other transition.
- Reset (rst_n=0 at an edge, including mid-transfer): m_v=0, s_v=0, result=0, zero=0, overflow=0, illegal_op=0, in_ready=1 after the edge. Buffered data is discarded.
- Data registers are not cleared by flush; only the valid bits are.

Test Plan:
- Reset then add: alu_ctl=0010, A=5, B=7, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, overflow=0.
- Overflow/zero:
  - add 0x7FFFFFFF+1 -> result 0x80000000, overflow=1.
  - sub 9−9 -> result 0, zero=1, overflow=0.
  - slt A=0xFFFFFFFF (−1), B=1 -> result 1.
- Illegal code: alu_ctl=1111, A=3, B=4 -> result 0, zero=1, illegal_op=1.
- Backpressure: 4 back-to-back ops (and, or, nor, xor on A=0xF0F0F0F0, B=0xFF00FF00), out_ready=0 after the first accept -> in_ready low after 2 entries held. Then out_ready=1 -> results emerge in order 0xF000F000, 0xFFF0FFF0, 0x000F000F, 0x0FF00FF0. No loss or duplication.
- Flush: both entries full, assert flush 1 cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input is never output.
- Mid-stream reset: rst_n=0 while m_v=s_v=1 -> after the edge all outputs 0, in_ready=1. A new add 1+1 then yields result 2 one cycle after accept.
